// File: rtl/interfaz_adc_pkg.sv
// -----------------------------------------------------------------------------
// interfaz_adc_pkg
// Shared definitions for the ADC front end that feeds the filter:
//   - default sample format (Width / Presicion) and ADC resolution
//   - serial frame geometry (16 clocks per frame, 4 leading zero bits)
//   - FSM state encoding used by interfaz_adc
// -----------------------------------------------------------------------------
package interfaz_adc_pkg;

    // Default sample format seen by the filter
    localparam int WIDTH_DEF     = 23;
    localparam int PRESICION_DEF = 14;
    localparam int ADC_BITS_DEF  = 12;

    // Serial frame: 16 adc_sclk periods, the first 4 bits are leading zeros
    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } adc_state_t;

endpackage

// File: rtl/interfaz_adc_generador_muestreo.sv
// -----------------------------------------------------------------------------
// generador_muestreo
// Sample-period generator. Counts 0..SampleDiv-1 while run is high and emits a
// one-clock tick once per period; the counter is held at 0 while run is low.
// The tick is registered, so the first tick lands exactly SampleDiv clocks
// after run rises.
//
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous reset, active-low
//   run    in   acquisition enable (level)
//   tick   out  one-clock pulse, once per sample period
// -----------------------------------------------------------------------------
module generador_muestreo #(
    parameter int SampleDiv = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(SampleDiv);
    localparam logic [CW-1:0] COUNT_LAST = CW'(SampleDiv - 1);

    logic [CW-1:0] count_reg;
    logic          tick_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else if (!run) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            // Tick is raised for the cycle following count == SampleDiv-1
            tick_reg <= (count_reg == COUNT_LAST);
            if (count_reg == COUNT_LAST) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/interfaz_adc.sv
// -----------------------------------------------------------------------------
// interfaz_adc
// Serial ADC front end. Once per sample period it runs one 16-bit SPI-style
// frame (chip select, 16 adc_sclk periods), keeps the last AdcBits bits as an
// offset-binary code, converts it to a signed fixed-point sample and presents
// it on uk with a one-clock enable strobe for the filter.
//
// Ports:
//   clock      in   system clock (rising edge)
//   reset      in   asynchronous reset, active-low
//   run        in   acquisition enable (level)
//   adc_sdata  in   ADC serial data, MSB first, changes on adc_sclk fall
//   adc_cs_n   out  ADC chip select, active-low
//   adc_sclk   out  ADC serial clock, idle high
//   uk         out  signed sample (Width bits, Presicion fractional bits)
//   enable     out  one-clock strobe, new uk valid
//   overrun    out  sticky: a sample tick arrived while a frame was running
// -----------------------------------------------------------------------------
module interfaz_adc
    import interfaz_adc_pkg::*;
#(
    parameter int Width     = WIDTH_DEF,
    parameter int Presicion = PRESICION_DEF,
    parameter int AdcBits   = ADC_BITS_DEF,
    parameter int ClkDiv    = 2,
    parameter int SampleDiv = 100
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    adc_sdata,
    output logic                    adc_cs_n,
    output logic                    adc_sclk,
    output logic signed [Width-1:0] uk,
    output logic                    enable,
    output logic                    overrun
);

    // Only the trailing data bits are kept: leading bits fall off the top
    localparam int DATA_BITS = FRAME_BITS - LEAD_ZEROS;
    localparam int SHIFT_AMT = Presicion - AdcBits + 1;
    localparam int PH_W      = $clog2(2 * ClkDiv) + 1;
    localparam int BIT_W     = $clog2(FRAME_BITS);

    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(ClkDiv - 1);
    localparam logic [PH_W-1:0]  PH_END   = PH_W'(2 * ClkDiv - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic signed [Width-1:0] CODE_MID = Width'(2 ** (AdcBits - 1));

    logic tick;

    generador_muestreo #(
        .SampleDiv (SampleDiv)
    ) u_muestreo (
        .clock (clock),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    adc_state_t             state_reg;
    logic [PH_W-1:0]        phase_reg;
    logic [BIT_W-1:0]       bit_cnt_reg;
    logic [DATA_BITS-1:0]   shreg_reg;
    logic                   cs_n_reg;
    logic                   sclk_reg;
    logic signed [Width-1:0] uk_reg;
    logic                   enable_reg;
    logic                   overrun_reg;

    // Offset-binary to two's complement, then align to the Presicion point
    logic [AdcBits-1:0]      code;
    logic signed [Width-1:0] code_centered;
    logic signed [Width-1:0] uk_conv;

    assign code          = shreg_reg[AdcBits-1:0];
    assign code_centered = $signed({{(Width - AdcBits){1'b0}}, code}) - CODE_MID;
    assign uk_conv       = code_centered <<< SHIFT_AMT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            phase_reg   <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            cs_n_reg    <= 1'b1;
            sclk_reg    <= 1'b1;
            uk_reg      <= '0;
            enable_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            enable_reg <= 1'b0;

            // Ticks outside IDLE are dropped; only record that it happened
            if (tick && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    cs_n_reg <= 1'b1;
                    sclk_reg <= 1'b1;
                    if (tick) begin
                        state_reg   <= CS_SETUP;
                        cs_n_reg    <= 1'b0;
                        phase_reg   <= '0;
                        bit_cnt_reg <= '0;
                        shreg_reg   <= '0;
                    end
                end

                CS_SETUP: begin
                    if (phase_reg == PH_MID) begin
                        state_reg <= SHIFT;
                        phase_reg <= '0;
                        sclk_reg  <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end

                SHIFT: begin
                    // phase 0..ClkDiv-1 low, ClkDiv..2*ClkDiv-1 high
                    if (phase_reg == PH_END) begin
                        phase_reg <= '0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_reg  <= DONE;
                            cs_n_reg   <= 1'b1;
                            enable_reg <= 1'b1;
                            uk_reg     <= uk_conv;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            sclk_reg    <= 1'b0;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                        // Capture on the clock where adc_sclk rises
                        if (phase_reg == PH_MID) begin
                            sclk_reg  <= 1'b1;
                            shreg_reg <= {shreg_reg[DATA_BITS-2:0], adc_sdata};
                        end
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign adc_cs_n = cs_n_reg;
    assign adc_sclk = sclk_reg;
    assign uk       = uk_reg;
    assign enable   = enable_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_interfaz_adc.sv
// -----------------------------------------------------------------------------
// tb_interfaz_adc
// Bench for interfaz_adc: a behavioural ADC model serves 16-bit frames, the
// expected sample of each frame is queued when the frame starts and a
// separate monitor pops and checks it on every enable pulse, together with
// frame timing and adc_sclk shape. A second instance with a short sample
// period exercises the overrun flag.
// -----------------------------------------------------------------------------
module tb_interfaz_adc;

    localparam int W  = 23;
    localparam int P  = 14;
    localparam int A  = 12;
    localparam int CD = 2;
    localparam int SD = 100;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic run = 1'b0;
    logic adc_sdata = 1'b0;
    logic adc_cs_n;
    logic adc_sclk;
    logic signed [W-1:0] uk;
    logic enable;
    logic overrun;

    logic reset2 = 1'b0;
    logic run2 = 1'b0;
    logic adc_cs_n2;
    logic adc_sclk2;
    logic signed [W-1:0] uk2;
    logic enable2;
    logic overrun2;

    always #5 clock = ~clock;

    interfaz_adc #(
        .Width(W), .Presicion(P), .AdcBits(A), .ClkDiv(CD), .SampleDiv(SD)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .adc_sdata(adc_sdata),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .uk(uk),
        .enable(enable), .overrun(overrun)
    );

    interfaz_adc #(
        .Width(W), .Presicion(P), .AdcBits(A), .ClkDiv(CD), .SampleDiv(50)
    ) dut_ovr (
        .clock(clock), .reset(reset2), .run(run2), .adc_sdata(1'b0),
        .adc_cs_n(adc_cs_n2), .adc_sclk(adc_sclk2), .uk(uk2),
        .enable(enable2), .overrun(overrun2)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input int got, input int expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference conversion: centre the offset-binary code, scale to Presicion
    function automatic int ref_uk(input int code);
        return (code - 2 ** (A - 1)) * (2 ** (P - A + 1));
    endfunction

    // ---------------- ADC model + scoreboard producer ----------------
    int exp_q[$];
    int code_q[$];
    logic [15:0] adc_word = 16'h0;
    int bit_idx = 0;

    always @(negedge adc_cs_n) begin
        int code;
        logic [3:0] nib;
        if (code_q.size() > 0) begin
            code = code_q.pop_front();
            nib = 4'h0;
        end else begin
            code = int'($urandom_range(0, 4095));
            nib = 4'($urandom_range(0, 15));
        end
        adc_word = {nib, 12'(code)};
        bit_idx = 16;
        exp_q.push_back(ref_uk(code));
    end

    // New bit on every adc_sclk fall; the first fall presents the MSB
    always @(negedge adc_sclk) begin
        if (!adc_cs_n && bit_idx > 0) begin
            bit_idx--;
            adc_sdata = adc_word[bit_idx];
        end
    end

    // ---------------- monitor ----------------
    int n_en = 0;
    int last_en = -1;
    int first_due = -1;
    int n_csfall = 0;
    int last_csfall = -1;
    bit in_frame = 1'b0;
    int rises = 0;
    int low_cycles = 0;
    int run_len = 0;
    int bad_phase = 0;
    int idle_viol = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b1;
    logic prev_en = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            in_frame = 1'b0;
            prev_cs = 1'b1;
            prev_sclk = 1'b1;
            prev_en = 1'b0;
        end else begin
            if (adc_cs_n && !adc_sclk) idle_viol++;

            if (prev_cs && !adc_cs_n) begin
                in_frame = 1'b1;
                n_csfall++;
                last_csfall = cyc;
                rises = 0;
                low_cycles = 0;
                bad_phase = 0;
            end

            if (in_frame) begin
                if (!adc_cs_n) begin
                    low_cycles++;
                    if (prev_cs) begin
                        run_len = 1;
                    end else if (adc_sclk == prev_sclk) begin
                        run_len++;
                    end else begin
                        if (run_len != CD) bad_phase++;
                        if (adc_sclk) rises++;
                        run_len = 1;
                    end
                end else begin
                    if (adc_sclk != prev_sclk || run_len != CD) bad_phase++;
                    chk("sclk_rises_per_frame", rises, 16);
                    chk("cs_low_cycles", low_cycles, 33 * CD);
                    chk("sclk_phase_errors", bad_phase, 0);
                    in_frame = 1'b0;
                end
            end

            if (enable) begin
                n_en++;
                chk("enable_width", int'(prev_en), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_enable: got uk=%0d with no frame expected (cycle %0d)",
                             int'(uk), cyc);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    $display("frame %0d: uk=%0d expected=%0d cycle=%0d", n_en, int'(uk), e, cyc);
                    chk("uk", int'(uk), e);
                end
                if (first_due >= 0) begin
                    chk("first_enable_cycle", cyc, first_due);
                    first_due = -1;
                end else if (last_en >= 0) begin
                    chk("enable_gap", cyc - last_en, SD);
                end
                last_en = cyc;
            end

            prev_en = enable;
            prev_cs = adc_cs_n;
            prev_sclk = adc_sclk;
        end
    end

    task automatic wait_en(input int target, input int budget);
        int k = 0;
        while (n_en < target && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("enable_count_reached", n_en >= target ? target : n_en, target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int k;
        int f;
        int e;
        int r;

        repeat (3) @(negedge clock);
        chk("reset_cs_n", int'(adc_cs_n), 1);
        chk("reset_sclk", int'(adc_sclk), 1);
        chk("reset_uk", int'(uk), 0);
        chk("reset_enable", int'(enable), 0);
        chk("reset_overrun", int'(overrun), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Directed codes first, then random frames
        code_q = '{4095, 2048, 0, 2049};
        @(negedge clock);
        run = 1'b1;
        t0 = cyc;
        first_due = t0 + 167;
        k = 0;
        while (n_csfall == 0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("first_cs_fall_cycle", last_csfall, t0 + SD + 1);
        wait_en(10, 1200);

        // Reset in the middle of a frame, at the 8th adc_sclk rise
        k = 0;
        while (!(in_frame && rises == 8) && k < 300) begin
            @(negedge clock);
            k++;
        end
        chk("reached_8th_rise", rises, 8);
        #2 reset = 1'b0;
        #1;
        chk("midreset_cs_n", int'(adc_cs_n), 1);
        chk("midreset_sclk", int'(adc_sclk), 1);
        chk("midreset_uk", int'(uk), 0);
        chk("midreset_enable", int'(enable), 0);
        exp_q.delete();
        bit_idx = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        first_due = cyc + 167;
        wait_en(n_en + 2, 400);

        // Drop run 10 clocks into a frame
        f = n_csfall;
        k = 0;
        while (n_csfall == f && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("frame_started", n_csfall, f + 1);
        repeat (10) @(negedge clock);
        run = 1'b0;
        e = n_en;
        f = n_csfall;
        repeat (300) @(negedge clock);
        chk("enable_after_run_drop", n_en, e + 1);
        chk("cs_activity_after_drop", n_csfall, f);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("main_overrun", int'(overrun), 0);
        chk("sclk_high_when_idle_violations", idle_viol, 0);

        // Short sample period: second tick lands inside the first frame
        @(negedge clock);
        reset2 = 1'b1;
        run2 = 1'b1;
        r = cyc;
        repeat (60) @(negedge clock);
        chk("ovr_after_first_tick", int'(overrun2), 0);
        repeat (45) @(negedge clock);
        chk("ovr_after_second_tick", int'(overrun2), 1);
        run2 = 1'b0;
        repeat (200) @(negedge clock);
        chk("ovr_sticky", int'(overrun2), 1);
        #2 reset2 = 1'b0;
        #1;
        chk("ovr_cleared_by_reset", int'(overrun2), 0);
        chk("ovr_reset_cycle_ref", cyc - r >= 305 ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interfaz_adc.md
INTERFAZ_ADC -- requirements
Module: interfaz_adc

Interface
REQ-001 Parameter Width, default 23: width of the signed fixed-point output sample.
REQ-002 Parameter Presicion, default 14: fractional bits of the output sample.
REQ-003 Parameter AdcBits, default 12: ADC resolution, unsigned offset-binary code.
REQ-004 Parameter ClkDiv, default 2: clock cycles per adc_sclk half-period, minimum 1.
REQ-005 Parameter SampleDiv, default 100: clock cycles per sample period, minimum 33*ClkDiv+2.
REQ-006 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-007 clock  input  1  system clock, all logic on rising edge.
REQ-008 reset  input  1  asynchronous reset, active-low.
REQ-009 run  input  1  acquisition enable, level.
REQ-010 adc_sdata  input  1  serial data from ADC, MSB first, changes on adc_sclk falling edge.
REQ-011 adc_cs_n  output  1  ADC chip select, active-low.
REQ-012 adc_sclk  output  1  ADC serial clock, idle high.
REQ-013 uk  output  Width signed  sample for the filter input, held between updates.
REQ-014 enable  output  1  one-clock strobe marking a new uk; drives the filter enable.
REQ-015 overrun  output  1  sticky flag: a sample tick arrived while a frame was in progress.

Function
REQ-016 Sample counter: counts 0..SampleDiv-1 while run=1; held at 0 while run=0; tick when count = SampleDiv-1.
REQ-017 The first tick occurs SampleDiv clocks after run rises.
REQ-018 FSM states: IDLE, CS_SETUP, SHIFT, DONE. All outputs are registered.
REQ-019 IDLE: adc_cs_n=1, adc_sclk=1. Tick -> CS_SETUP on the next clock.
REQ-020 CS_SETUP: adc_cs_n=0, adc_sclk=1 for ClkDiv clocks, then -> SHIFT.
REQ-021 SHIFT: 16 adc_sclk periods, each ClkDiv clocks low followed by ClkDiv clocks high.
REQ-022 SHIFT capture: adc_sdata is sampled on the clock where adc_sclk goes low->high.
REQ-023 SHIFT data: the first 4 captured bits are leading zeros and are discarded; the last AdcBits bits form the code, MSB first.
REQ-024 After 32*ClkDiv clocks in SHIFT -> DONE.
REQ-025 DONE lasts one clock: adc_cs_n=1, enable=1, uk loaded; then -> IDLE.
REQ-026 Latency: enable asserts exactly 33*ClkDiv+1 clocks after the tick cycle (67 at defaults).
REQ-027 Conversion: uk = sign_extend((code - 2^(AdcBits-1)) << (Presicion-AdcBits+1)) to Width bits.
REQ-028 Conversion examples at defaults: code 4095 -> 16376; code 2048 -> 0; code 0 -> -16384; code 2049 -> 8.
REQ-029 A tick in any state other than IDLE sets overrun and is ignored; the frame in progress completes unchanged.
REQ-030 run falling mid-frame: the current frame completes and issues its enable; no further frames start.
REQ-031 enable is 0 in every cycle other than DONE; uk changes only in DONE.

Reset
REQ-032 Reset asserted (low) at any time, including mid-frame, immediately forces:
  - adc_cs_n=1, adc_sclk=1
  - uk=0, enable=0, overrun=0
  - FSM to IDLE
  - sample counter, bit counter and shift register to 0
REQ-033 After reset releases, no partial frame resumes; the next frame starts on the next tick.

Structure
REQ-034 The shared filter package holds:
  - Width, Presicion and AdcBits defaults
  - frame length (16) and leading-zero count (4)
  - FSM state encoding
REQ-035 The sample counter is a separate sub-module, generador_muestreo (parameter SampleDiv; inputs clock, reset, run; output tick).
REQ-036 The adc_sclk phase counter, bit counter, shift register and FSM stay in interfaz_adc.

Verification
REQ-037 Reset release, run=1, ADC model returns 0000_1111_1111_1111 -> first tick at clock 100; enable at clock 167; uk=16376; adc_cs_n low for exactly 66 clocks.
REQ-038 Frames returning code 2048 then code 0 -> uk=0 then uk=-16384; successive enable pulses exactly 100 clocks apart.
REQ-039 Bench checks the 16-bit frame -> exactly 16 adc_sclk rising edges per frame, each high and low phase 2 clocks, adc_sclk high whenever adc_cs_n=1.
REQ-040 Reset pulsed low at the 8th adc_sclk edge -> adc_cs_n=1 and adc_sclk=1 immediately; uk=0; no enable until a fresh frame completes 167 clocks after release.
REQ-041 run dropped 10 clocks into a frame -> that frame's enable still occurs; no further adc_cs_n activity.
REQ-042 SampleDiv forced to 50 -> overrun=1 after the second tick; overrun stays 1 until reset.
